rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_if.sv | 25 ++
 rtl/rom_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rom_loader_if.sv
// Load-stream handshake plus ROM write port and CPU release/status signals of rom_loader.
// The master drives the byte stream; the slave is the loader.
interface rom_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_resetb;
  logic              done;
  logic              err;

  modport master (
    output load_valid, load_data,
    input  load_ready, mem_we, mem_addr, mem_wdata, cpu_resetb, done, err
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, mem_we, mem_addr, mem_wdata, cpu_resetb, done, err
  );
endinterface

// File: rtl/rom_loader.sv
// Boot ROM loader: parses an address/length/data/checksum byte stream, writes the ROM,
// then releases the CPU reset a fixed delay after a good checksum.
module rom_loader #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic         ph1,
  input  logic         reset,
  rom_loader_if.slave  bus
);

  localparam int unsigned LEN_W     = 16;
  localparam int unsigned ROM_BYTES = 32'(1) << ADDR_W;
  localparam int unsigned DLY_W     = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;

  typedef enum logic [3:0] {
    A_LO, A_HI, L_LO, L_HI, DATA, CSUM, HOLD, RUN, ERR
  } state_e;

  state_e            state_q;
  logic [7:0]        lo_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        acc_q, acc_d;
  logic [DLY_W-1:0]  dly_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              resetb_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic [LEN_W-1:0]  len_n;

  // Byte handshake and the next values of the data-phase registers.
  always_comb begin
    accept    = bus.load_valid & ready_q;
    len_n     = {bus.load_data, lo_q};
    wr_addr_d = wr_addr_q + ADDR_W'(1);
    cnt_d     = cnt_q - LEN_W'(1);
    acc_d     = acc_q ^ bus.load_data;
  end

  // Stream parser FSM with registered outputs; lo_q latches the low byte of both header fields.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q   <= A_LO;
      lo_q      <= 8'd0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      acc_q     <= 8'd0;
      dly_q     <= '0;
      ready_q   <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'd0;
      resetb_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        A_LO: if (accept) begin
          lo_q    <= bus.load_data;
          state_q <= A_HI;
        end
        A_HI: if (accept) begin
          wr_addr_q <= ADDR_W'({bus.load_data, lo_q});
          state_q   <= L_LO;
        end
        L_LO: if (accept) begin
          lo_q    <= bus.load_data;
          state_q <= L_HI;
        end
        L_HI: if (accept) begin
          if (len_n == '0) begin
            state_q <= CSUM;
          end else if (32'(len_n) > ROM_BYTES) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            cnt_q   <= len_n;
            state_q <= DATA;
          end
        end
        DATA: if (accept) begin
          we_q      <= 1'b1;
          addr_q    <= wr_addr_q;
          wdata_q   <= bus.load_data;
          wr_addr_q <= wr_addr_d;
          acc_q     <= acc_d;
          cnt_q     <= cnt_d;
          if (cnt_q == LEN_W'(1)) state_q <= CSUM;
        end
        CSUM: if (accept) begin
          ready_q <= 1'b0;
          dly_q   <= '0;
          if (bus.load_data == acc_q) begin
            state_q <= HOLD;
          end else begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end
        end
        // Release delay: HOLD lasts exactly RELEASE_DLY cycles.
        HOLD: begin
          if (dly_q == DLY_W'(RELEASE_DLY - 1)) begin
            state_q  <= RUN;
            resetb_q <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            dly_q <= dly_q + DLY_W'(1);
          end
        end
        RUN, ERR: ;
        default: begin
          state_q <= ERR;
          err_q   <= 1'b1;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_resetb = resetb_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
